alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
// - Initiator side of the 5-bit ALU operand/select interface: buffers operation requests in a small FIFO.
// - Issues one request at a time on alu_a/alu_b/alu_sel to a combinational 5-bit ALU (AND/ADD/OR/XOR).
// - Captures alu_out and returns it upstream over a valid/ready response channel.
// - Sits between a request source (test/control logic) and the ALU.
// PARAMETERS
// - DEPTH   4   request FIFO entries (power of 2, >=2)
// - AW      2   FIFO pointer width, log2(DEPTH)
// PORTS
// - clk        in   1      single clock, all logic on rising edge
// - rst        in   1      synchronous reset, active-high
// - req_valid  in   1      request present
// - req_ready  out  1      FIFO can accept; = !full
// - req_a      in   5      operand A
// - req_b      in   5      operand B
// - req_op     in   2      00 AND, 01 ADD, 10 OR, 11 XOR
// - alu_a      out  5      registered operand A to ALU
// - alu_b      out  5      registered operand B to ALU
// - alu_sel    out  2      registered select to ALU
// - alu_out    in   5      combinational ALU result
// - rsp_valid  out  1      result held on rsp_data
// - rsp_ready  in   1      consumer accepts result
// - rsp_data   out  5      captured result
// - rsp_op     out  2      op that produced rsp_data
// - fifo_count out  AW+1   occupied FIFO entries, 0..DEPTH
// BEHAVIOUR
// - Reset (rst=1 at edge): FIFO emptied, pointers/count 0, state IDLE, alu_a/alu_b/rsp_data 0, alu_sel/rsp_op 00, rsp_valid 0.
// - Reset mid-operation: in-flight and queued requests are discarded; no response is produced for them.
// - Push: req_valid && req_ready at an edge writes {req_op,req_a,req_b}; wr pointer wraps DEPTH-1 -> 0.
// - Full: req_ready=0 when count==DEPTH, even if a pop occurs in the same cycle.
// - Simultaneous push+pop (not full): count unchanged, both pointers advance.
// - Empty: IDLE remains IDLE; alu_* hold their last values.
// - FSM IDLE: if count!=0, pop head into alu_a/alu_b/alu_sel -> EXEC; else stay.
// - FSM EXEC: rsp_data<=alu_out, rsp_op<=alu_sel, rsp_valid<=1 -> RESP.
// - FSM RESP: hold rsp_data/rsp_op/rsp_valid stable while rsp_ready=0.
// - FSM RESP, rsp_ready=1 at an edge: rsp_valid<=0 -> IDLE.
// - Latency: request accepted at edge N on an empty, idle block -> ALU driven after edge N+1 -> rsp_valid=1 after edge N+2.
// - Throughput: at most one result per 3 cycles.
// - Arithmetic: the ALU computes everything; ADD is mod 32 with carry dropped and no overflow flag.
// - Ordering: responses are returned strictly in request order.
// CONFIGURATION
// - Macro ALU_SEQ_CHAIN_EN.
// - Defined: extra input req_chain (1 bit) is stored with each entry; at pop, an entry with req_chain=1 takes alu_a from the
//   last delivered rsp_data instead of its stored req_a. That last value is 0 after reset.
// - Not defined: port req_chain is absent and alu_a is always the stored req_a.
// TESTING
// - Op sweep, A=22 B=13, ops 00/01/10/11 -> rsp_data 4/3/31/27 in order; rsp_op matches each request.
// - Latency: single ADD 1+1 accepted at edge N -> rsp_valid=1 after edge N+2, rsp_data=2.
// - Full: hold rsp_ready=0 and push 6 requests -> first 4 accepted plus 1 popped into flight; fifo_count=4, req_ready=0;
//   releasing rsp_ready drains all 5 in order.
// - Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable; one handshake gives one response.
// - Reset in EXEC with 3 queued -> next cycle rsp_valid=0, fifo_count=0, req_ready=1; no stale response appears.
// - Chain (ALU_SEQ_CHAIN_EN): ADD 30+5 (=3), then XOR chain=1 b=1 -> 2, then AND chain=1 b=6 -> 2.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for a 5-bit combinational ALU (AND/ADD/OR/XOR).
// Requests are queued in a DEPTH-entry FIFO and issued one at a time on
// alu_a/alu_b/alu_sel. The ALU result is captured and returned on a
// valid/ready response channel, strictly in request order.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   Defined     : adds input req_chain, stored with each entry. A popped entry
//                 with req_chain=1 takes alu_a from the last delivered rsp_data.
//                 That value is 0 after reset.
//   Not defined : no req_chain port, and alu_a is always the stored req_a.
//
// Handshake rules (both channels): a transfer happens at a rising edge where
// valid && ready are both 1. The producer holds its payload stable while valid
// is 1 and ready is 0. req_ready is !full and does not depend on req_valid.
// rsp_valid, rsp_data and rsp_op are registered and held until the handshake.
//
// FSM: IDLE -> (FIFO not empty: pop head into ALU regs) -> EXEC
//      EXEC -> (capture alu_out) -> RESP
//      RESP -> (rsp_ready) -> IDLE
// fsm_state exposes the current state for debug and checker binding.

module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_a,
  input  logic [4:0]    req_b,
  input  logic [1:0]    req_op,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic          req_chain,
`endif
  output logic [4:0]    alu_a,
  output logic [4:0]    alu_b,
  output logic [1:0]    alu_sel,
  input  logic [4:0]    alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [4:0]    rsp_data,
  output logic [1:0]    rsp_op,
  output logic [AW:0]   fifo_count,
  output logic [1:0]    fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

`ifdef ALU_SEQ_CHAIN_EN
  localparam int EW = 13;
`else
  localparam int EW = 12;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;

  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [1:0]    head_op;
  logic [4:0]    head_a;
  logic [4:0]    head_b;
  logic [4:0]    issue_a;

  assign req_ready  = (count != FULL_CNT);
  assign push       = req_valid && req_ready;
  // Pop only from IDLE, so at most one request is ever in flight.
  assign pop        = (state == S_IDLE) && (count != '0);
  assign fifo_count = count;
  assign fsm_state  = state;
  assign head       = mem[rd_ptr];

`ifdef ALU_SEQ_CHAIN_EN
  logic head_chain;
  assign wr_entry = {req_chain, req_op, req_a, req_b};
  assign {head_chain, head_op, head_a, head_b} = head;
  // A pop only happens in IDLE, after the previous result was delivered,
  // so rsp_data is exactly the last delivered result here.
  assign issue_a = head_chain ? rsp_data : head_a;
`else
  assign wr_entry = {req_op, req_a, req_b};
  assign {head_op, head_a, head_b} = head;
  assign issue_a = head_a;
`endif

  // FIFO storage: contents need no reset, emptiness comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + ONE_CNT;
      end else if (pop && !push) begin
        count <= count - ONE_CNT;
      end
    end
  end

  // Issue/capture/respond sequencer and its output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 2'b00;
      rsp_data  <= '0;
      rsp_op    <= 2'b00;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a   <= issue_a;
            alu_b   <= head_b;
            alu_sel <= head_op;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_out;
          rsp_op    <= alu_sel;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: provides the combinational ALU, drives directed
// request/response traffic, and checks every response against a queue-based
// model of ordered request results, plus hand-computed literal expectations.

module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_a;
  logic [4:0]  req_b;
  logic [1:0]  req_op;
  logic        req_chain;
  logic [4:0]  alu_a;
  logic [4:0]  alu_b;
  logic [1:0]  alu_sel;
  logic [4:0]  alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_data;
  logic [1:0]  rsp_op;
  logic [AW:0] fifo_count;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain  (req_chain),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .fifo_count (fifo_count),
    .fsm_state  (fsm_state)
  );

  // The ALU this block drives: plain combinational 5-bit ops.
  always_comb begin
    alu_out = alu_calc(alu_a, alu_b, alu_sel);
  end

  function automatic logic [4:0] alu_calc(input logic [4:0] a, input logic [4:0] b,
                                          input logic [1:0] op);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00:   return a & b;
      2'b01:   return sum[4:0];
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [6:0]  exp_q[$];   // {op, result} in request order
  logic [6:0]  rsp_log[$]; // responses actually handed over
  logic [4:0]  last_exp = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model + compare: sampled on the falling edge, when inputs and outputs are stable.
  always @(negedge clk) begin
    logic [4:0] a_eff;
    logic [4:0] res;
    if (rst) begin
      exp_q.delete();
      last_exp = '0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_data", 32'(rsp_data), 32'(exp_q[0][4:0]));
          check("rsp_op", 32'(rsp_op), 32'(exp_q[0][6:5]));
          if (rsp_ready) begin
            rsp_log.push_back({rsp_op, rsp_data});
            void'(exp_q.pop_front());
          end
        end
      end
      if (req_valid && req_ready) begin
        a_eff = (CHAIN_EN && req_chain) ? last_exp : req_a;
        res   = alu_calc(a_eff, req_b, req_op);
        exp_q.push_back({req_op, res});
        last_exp = res;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request for exactly one rising edge; called just after an edge.
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op,
                       input logic ch);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_chain = ch;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !rsp_valid && fifo_count == '0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_valid_within_budget", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [4:0] sweep_exp [4];
    sweep_exp = '{5'd4, 5'd3, 5'd31, 5'd27};
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    req_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_alu_b", 32'(alu_b), 32'd0);
    check("reset_alu_sel", 32'(alu_sel), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_op", 32'(rsp_op), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: ADD 1+1 accepted at edge N.
    drive(5'd1, 5'd1, 2'b01, 1'b0);
    check("lat_n_count", 32'(fifo_count), 32'd1);
    check("lat_n_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_n1_alu_a", 32'(alu_a), 32'd1);
    check("lat_n1_alu_b", 32'(alu_b), 32'd1);
    check("lat_n1_alu_sel", 32'(alu_sel), 32'd1);
    check("lat_n1_valid", 32'(rsp_valid), 32'd0);
    check("lat_n1_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", 32'(rsp_valid), 32'd1);
    check("lat_n2_data", 32'(rsp_data), 32'd2);
    rsp_ready = 1'b1;
    wait_drain(20);

    // Op sweep A=22 B=13.
    rsp_log.delete();
    for (int i = 0; i < 4; i++) drive(5'd22, 5'd13, 2'(i), 1'b0);
    wait_drain(100);
    check("sweep_count", 32'(rsp_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      check("sweep_value", 32'(rsp_log[i]), 32'({2'(i), sweep_exp[i]}));
    check("idle_hold_alu_a", 32'(alu_a), 32'd22);
    check("idle_hold_alu_b", 32'(alu_b), 32'd13);
    check("idle_hold_alu_sel", 32'(alu_sel), 32'd3);

    // Full: six pushes against a stalled consumer.
    rsp_ready = 1'b0;
    rsp_log.delete();
    for (int i = 0; i < 6; i++) drive(5'(i + 1), 5'd2, 2'b01, 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    check("full_accepted", 32'(exp_q.size()), 32'd5);
    rsp_ready = 1'b1;
    wait_drain(200);
    check("full_drain_count", 32'(rsp_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < rsp_log.size(); i++)
      check("full_drain_value", 32'(rsp_log[i]), 32'({2'b01, 5'(i + 3)}));

    // Backpressure: XOR 5^3 held for 10 cycles, then one handshake.
    rsp_ready = 1'b0;
    rsp_log.delete();
    drive(5'd5, 5'd3, 2'b11, 1'b0);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_data_held", 32'(rsp_data), 32'd6);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_after_handshake", 32'(rsp_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("bp_one_response", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) check("bp_response", 32'(rsp_log[0]), 32'({2'b11, 5'd6}));

    // Reset while in EXEC with 3 requests still queued.
    drive(5'd2, 5'd2, 2'b00, 1'b0);
    wait_valid(20);
    for (int i = 0; i < 4; i++) drive(5'(i + 3), 5'd1, 2'b01, 1'b0);
    check("rst_pre_count", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_exec_count", 32'(fifo_count), 32'd3);
    check("rst_exec_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    rsp_log.delete();
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_stale", 32'(rsp_log.size()), 32'd0);
    check("rst_still_empty", 32'(fifo_count), 32'd0);

    // Chain: ADD 30+5=3, XOR chain b=1 -> 2, AND chain b=6 -> 2.
    if (CHAIN_EN) begin
      rsp_log.delete();
      drive(5'd30, 5'd5, 2'b01, 1'b0);
      drive(5'd9, 5'd1, 2'b11, 1'b1);
      drive(5'd0, 5'd6, 2'b00, 1'b1);
      wait_drain(100);
      check("chain_count", 32'(rsp_log.size()), 32'd3);
      if (rsp_log.size() == 3) begin
        check("chain_0", 32'(rsp_log[0]), 32'({2'b01, 5'd3}));
        check("chain_1", 32'(rsp_log[1]), 32'({2'b11, 5'd2}));
        check("chain_2", 32'(rsp_log[2]), 32'({2'b00, 5'd2}));
      end
    end

    check("model_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
